// File: rtl/gshare_branch_predictor.sv
// gshare_branch_predictor
//
// Gshare direction predictor for the lc3b fetch stage. A table of 2-bit
// saturating counters (the PHT) is indexed by the branch PC XOR-ed with a
// speculative global history register. Fetch looks up a prediction every
// cycle, and writeback later trains the indexed counter. On a mispredict,
// writeback also restores the history from the checkpoint taken at lookup.
// After reset, a sweep writes INIT_CTR into every PHT entry. The block
// reports not-ready until the sweep has finished.
//
// Ports
//   clk               clock; all state changes on the rising edge
//   reset             synchronous, active-high; restarts the init sweep
//   lookup_valid      fetch is predicting a branch this cycle
//   lookup_pc         16-bit PC of the branch being fetched
//   predict_taken     combinational prediction (0 while not ready)
//   predict_index     PHT index used by this lookup (carried to update_index)
//   predict_history   speculative history before this lookup (checkpoint)
//   update_valid      writeback resolves a conditional branch
//   update_index      predict_index captured at lookup
//   update_taken      resolved direction
//   update_mispredict resolved direction differs from the prediction
//   update_history    predict_history captured at lookup
//   ready             PHT initialised; lookups and updates are honoured

module gshare_branch_predictor #(
    parameter int         HIST_BITS  = 4,
    parameter int         INDEX_BITS = 6,
    parameter logic [1:0] INIT_CTR   = 2'b01
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  lookup_valid,
    input  logic [15:0]           lookup_pc,
    output logic                  predict_taken,
    output logic [INDEX_BITS-1:0] predict_index,
    output logic [HIST_BITS-1:0]  predict_history,
    input  logic                  update_valid,
    input  logic [INDEX_BITS-1:0] update_index,
    input  logic                  update_taken,
    input  logic                  update_mispredict,
    input  logic [HIST_BITS-1:0]  update_history,
    output logic                  ready
);

    localparam int PHT_SIZE = 1 << INDEX_BITS;

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]            state;
    logic [INDEX_BITS-1:0] sweep_ctr;
    logic [HIST_BITS-1:0]  spec_hist;
    logic [1:0]            pht [PHT_SIZE];

    logic [INDEX_BITS-1:0] hist_ext;
    logic [INDEX_BITS-1:0] lookup_index;
    logic [1:0]            lookup_ctr;
    logic [HIST_BITS-1:0]  hist_after_lookup;
    logic [HIST_BITS-1:0]  hist_after_restore;
    logic                  unused_pc_bits;

    // Index generation and the read side of the PHT. The history is
    // zero-extended so that it only folds into the low PC bits. The read is
    // purely combinational, so a same-cycle update is not visible to the
    // lookup.
    assign hist_ext        = INDEX_BITS'(spec_hist);
    assign lookup_index    = lookup_pc[INDEX_BITS:1] ^ hist_ext;
    assign lookup_ctr      = pht[lookup_index];
    assign ready           = (state == ST_RUN) && !reset;
    assign predict_taken   = ready && lookup_ctr[1];
    assign predict_index   = lookup_index;
    assign predict_history = spec_hist;

    // PC bit 0 and the bits above the index are unused.
    assign unused_pc_bits = ^lookup_pc;

    // Shift a new outcome into the history. The truncating cast drops the
    // oldest bit, so this also works for a one-bit history.
    assign hist_after_lookup  = HIST_BITS'({spec_hist, predict_taken});
    assign hist_after_restore = HIST_BITS'({update_history, update_taken});

    // Control state: the sweep counter, the INIT/RUN state and the
    // speculative history. While in RUN, a mispredict restore takes priority
    // over the speculative shift from a lookup in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_INIT;
            sweep_ctr <= '0;
            spec_hist <= '0;
        end else if (state == ST_INIT) begin
            sweep_ctr <= sweep_ctr + 1'b1;
            if (sweep_ctr == '1) begin
                state <= ST_RUN;
            end
        end else begin
            if (update_valid && update_mispredict) begin
                spec_hist <= hist_after_restore;
            end else if (lookup_valid) begin
                spec_hist <= hist_after_lookup;
            end
        end
    end

    // PHT write port. Reset does not clear the table directly. During INIT,
    // the sweep writes one entry per cycle. During RUN, resolved branches
    // train their counter, which saturates at both ends.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == ST_INIT) begin
                pht[sweep_ctr] <= INIT_CTR;
            end else if (update_valid) begin
                if (update_taken) begin
                    if (pht[update_index] != 2'b11) begin
                        pht[update_index] <= pht[update_index] + 2'd1;
                    end
                end else begin
                    if (pht[update_index] != 2'b00) begin
                        pht[update_index] <= pht[update_index] - 2'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_gshare_branch_predictor.sv
// tb_gshare_branch_predictor
//
// Self-checking bench for gshare_branch_predictor with its default
// parameters (4 history bits, 6 index bits, counters initialised to 01).
// A behavioural model holds the table as an integer array and the history
// as an integer. Every cycle, the DUT outputs are compared with this model.
// The bench also runs a vector table and some hand-written sequences with
// fixed expectations.

module tb_gshare_branch_predictor;

    localparam int HB   = 4;
    localparam int IB   = 6;
    localparam int SIZE = 64;
    localparam int INIT = 1;

    logic          clk;
    logic          reset;
    logic          lookup_valid;
    logic [15:0]   lookup_pc;
    logic          predict_taken;
    logic [IB-1:0] predict_index;
    logic [HB-1:0] predict_history;
    logic          update_valid;
    logic [IB-1:0] update_index;
    logic          update_taken;
    logic          update_mispredict;
    logic [HB-1:0] update_history;
    logic          ready;

    int checks   = 0;
    int failures = 0;

    // Behavioural model state.
    int m_pht [SIZE];
    bit m_run   = 1'b0;
    int m_sweep = 0;
    int m_hist  = 0;
    int m_pred  = 0;

    typedef struct {
        logic [15:0]   pc;
        logic          uv;
        logic [IB-1:0] ui;
        logic          ut;
        logic          exp_taken;
        logic [IB-1:0] exp_index;
    } vec_t;

    vec_t vecs [18];

    gshare_branch_predictor #(
        .HIST_BITS (HB),
        .INDEX_BITS(IB),
        .INIT_CTR  (2'b01)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .lookup_valid     (lookup_valid),
        .lookup_pc        (lookup_pc),
        .predict_taken    (predict_taken),
        .predict_index    (predict_index),
        .predict_history  (predict_history),
        .update_valid     (update_valid),
        .update_index     (update_index),
        .update_taken     (update_taken),
        .update_mispredict(update_mispredict),
        .update_history   (update_history),
        .ready            (ready)
    );

    // Free-running clock with a 10-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one value and count the result.
    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    // Drive the inputs just after the falling edge. Then compare the DUT's
    // combinational outputs with the model before the next rising edge.
    task automatic applyStimulus(input logic r, input logic lv, input logic [15:0] pc,
                                 input logic uv, input logic [IB-1:0] ui, input logic ut,
                                 input logic um, input logic [HB-1:0] uh);
        int m_ready;
        int m_idx;
        @(negedge clk);
        reset             = r;
        lookup_valid      = lv;
        lookup_pc         = pc;
        update_valid      = uv;
        update_index      = ui;
        update_taken      = ut;
        update_mispredict = um;
        update_history    = uh;
        #1;
        m_ready = (m_run && !r) ? 1 : 0;
        m_idx   = ((int'(pc) / 2) % SIZE) ^ m_hist;
        m_pred  = (m_ready == 1 && m_pht[m_idx] >= 2) ? 1 : 0;
        checkOutput("model_ready", int'(ready), m_ready);
        checkOutput("model_predict_taken", int'(predict_taken), m_pred);
        if (m_ready == 1) begin
            checkOutput("model_predict_index", int'(predict_index), m_idx);
            checkOutput("model_predict_history", int'(predict_history), m_hist);
        end
    endtask

    // Step through the rising edge, then apply that edge's effect to the model.
    task automatic advance();
        @(posedge clk);
        if (reset) begin
            m_run   = 1'b0;
            m_sweep = 0;
            m_hist  = 0;
        end else if (!m_run) begin
            m_pht[m_sweep] = INIT;
            m_sweep++;
            if (m_sweep == SIZE) m_run = 1'b1;
        end else begin
            if (update_valid) begin
                if (update_taken) m_pht[update_index] = (m_pht[update_index] == 3) ? 3 : m_pht[update_index] + 1;
                else              m_pht[update_index] = (m_pht[update_index] == 0) ? 0 : m_pht[update_index] - 1;
            end
            if (update_valid && update_mispredict)
                m_hist = (int'(update_history) * 2 + int'(update_taken)) % (1 << HB);
            else if (lookup_valid)
                m_hist = (m_hist * 2 + m_pred) % (1 << HB);
        end
    endtask

    task automatic cycle(input logic r, input logic lv, input logic [15:0] pc,
                         input logic uv, input logic [IB-1:0] ui, input logic ut,
                         input logic um, input logic [HB-1:0] uh);
        applyStimulus(r, lv, pc, uv, ui, ut, um, uh);
        advance();
    endtask

    // Count the not-ready cycles after reset, up to a fixed cycle limit.
    // The cycle in which ready first rises is also stepped.
    task automatic measure_init(input string name);
        int zeros;
        zeros = 0;
        for (int n = 0; n < 200; n++) begin
            applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, '0, 1'b0, 1'b0, '0);
            if (ready === 1'b1) break;
            zeros++;
            advance();
        end
        if (zeros < 200) advance();
        checkOutput(name, zeros, SIZE);
    endtask

    initial begin
        reset = 1'b0; lookup_valid = 1'b0; lookup_pc = '0; update_valid = 1'b0;
        update_index = '0; update_taken = 1'b0; update_mispredict = 1'b0; update_history = '0;
        for (int i = 0; i < SIZE; i++) m_pht[i] = 0;

        // Directed vectors: training on index 5, then saturation on index 9.
        // History stays 0 because lookup_valid is low and nothing mispredicts.
        vecs[0]  = '{16'h000A, 1'b1, 6'd5, 1'b1, 1'b0, 6'd5};
        vecs[1]  = '{16'h000A, 1'b1, 6'd5, 1'b1, 1'b1, 6'd5};
        vecs[2]  = '{16'h000A, 1'b0, 6'd0, 1'b0, 1'b1, 6'd5};
        vecs[3]  = '{16'h000A, 1'b1, 6'd5, 1'b0, 1'b1, 6'd5};
        vecs[4]  = '{16'h000A, 1'b0, 6'd0, 1'b0, 1'b1, 6'd5};
        vecs[5]  = '{16'h000A, 1'b1, 6'd5, 1'b0, 1'b1, 6'd5};
        vecs[6]  = '{16'h000A, 1'b0, 6'd0, 1'b0, 1'b0, 6'd5};
        vecs[7]  = '{16'h0012, 1'b1, 6'd9, 1'b0, 1'b0, 6'd9};
        vecs[8]  = '{16'h0012, 1'b1, 6'd9, 1'b0, 1'b0, 6'd9};
        vecs[9]  = '{16'h0012, 1'b1, 6'd9, 1'b0, 1'b0, 6'd9};
        vecs[10] = '{16'h0012, 1'b1, 6'd9, 1'b0, 1'b0, 6'd9};
        vecs[11] = '{16'h0012, 1'b1, 6'd9, 1'b1, 1'b0, 6'd9};
        vecs[12] = '{16'h0012, 1'b1, 6'd9, 1'b1, 1'b0, 6'd9};
        vecs[13] = '{16'h0012, 1'b1, 6'd9, 1'b1, 1'b1, 6'd9};
        vecs[14] = '{16'h0012, 1'b1, 6'd9, 1'b1, 1'b1, 6'd9};
        vecs[15] = '{16'h0012, 1'b1, 6'd9, 1'b1, 1'b1, 6'd9};
        vecs[16] = '{16'h0012, 1'b1, 6'd9, 1'b0, 1'b1, 6'd9};
        vecs[17] = '{16'h0012, 1'b0, 6'd0, 1'b0, 1'b1, 6'd9};

        // Reset for one cycle, then time the init sweep.
        applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, '0, 1'b0, 1'b0, '0);
        checkOutput("reset_ready", int'(ready), 0);
        checkOutput("reset_predict", int'(predict_taken), 0);
        advance();
        measure_init("init_cycles");

        // Every entry predicts not-taken after the sweep.
        for (int i = 0; i < SIZE; i++) begin
            applyStimulus(1'b0, 1'b1, 16'(i * 2), 1'b0, '0, 1'b0, 1'b0, '0);
            checkOutput("sweep_predict", int'(predict_taken), 0);
            checkOutput("sweep_index", int'(predict_index), i);
            advance();
        end

        // Vector table.
        for (int v = 0; v < 18; v++) begin
            applyStimulus(1'b0, 1'b0, vecs[v].pc, vecs[v].uv, vecs[v].ui, vecs[v].ut, 1'b0, '0);
            checkOutput("vec_taken", int'(predict_taken), int'(vecs[v].exp_taken));
            checkOutput("vec_index", int'(predict_index), int'(vecs[v].exp_index));
            advance();
        end

        // Mispredict restore: history 0011 with taken gives 0111.
        cycle(1'b0, 1'b0, 16'h0, 1'b1, 6'd40, 1'b1, 1'b1, 4'b0011);
        applyStimulus(1'b0, 1'b0, 16'h0010, 1'b0, '0, 1'b0, 1'b0, '0);
        checkOutput("restore_index", int'(predict_index), 'h0F);
        checkOutput("restore_history", int'(predict_history), 'b0111);
        advance();

        // Same-cycle restore beats a taken lookup. PC 0x1C with history 0111 hits index 9.
        applyStimulus(1'b0, 1'b1, 16'h001C, 1'b1, 6'd40, 1'b0, 1'b1, 4'b1000);
        checkOutput("collide_taken", int'(predict_taken), 1);
        checkOutput("collide_index", int'(predict_index), 9);
        advance();
        applyStimulus(1'b0, 1'b0, 16'h0012, 1'b0, '0, 1'b0, 1'b0, '0);
        checkOutput("collide_history", int'(predict_history), 0);
        advance();

        // A plain taken lookup shifts a 1 into the history.
        applyStimulus(1'b0, 1'b1, 16'h0012, 1'b0, '0, 1'b0, 1'b0, '0);
        checkOutput("shift_taken", int'(predict_taken), 1);
        advance();
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, '0, 1'b0, 1'b0, '0);
        checkOutput("shift_history", int'(predict_history), 1);
        advance();

        // Random traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            cycle(1'b0, 1'($urandom % 2), 16'($urandom), 1'(($urandom % 3) != 0),
                  IB'($urandom % SIZE), 1'($urandom % 2), 1'(($urandom % 4) == 0),
                  HB'($urandom));
        end

        // Train index 3 to strongly taken. Reset, interrupt the sweep at cycle 20,
        // and reset again. The sweep must then restart and clear the training.
        for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, 16'h0, 1'b1, 6'd3, 1'b1, 1'b0, '0);
        cycle(1'b1, 1'b0, 16'h0, 1'b0, '0, 1'b0, 1'b0, '0);
        for (int k = 0; k < 20; k++) cycle(1'b0, 1'b1, 16'h0006, 1'b1, 6'd3, 1'b1, 1'b1, '0);
        applyStimulus(1'b1, 1'b1, 16'h0006, 1'b0, '0, 1'b0, 1'b0, '0);
        checkOutput("midsweep_reset_ready", int'(ready), 0);
        checkOutput("midsweep_reset_predict", int'(predict_taken), 0);
        advance();
        measure_init("reinit_cycles");
        applyStimulus(1'b0, 1'b0, 16'h0006, 1'b0, '0, 1'b0, 1'b0, '0);
        checkOutput("reinit_index", int'(predict_index), 3);
        checkOutput("reinit_taken", int'(predict_taken), 0);
        advance();
        cycle(1'b0, 1'b0, 16'h0, 1'b1, 6'd3, 1'b1, 1'b0, '0);
        applyStimulus(1'b0, 1'b0, 16'h0006, 1'b0, '0, 1'b0, 1'b0, '0);
        checkOutput("reinit_one_taken", int'(predict_taken), 1);
        advance();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
